// File: rtl/mouse_paddle_pkg.sv
// Shared types and arithmetic helpers for the mouse-to-paddle emulator.
package mouse_paddle_pkg;

  typedef enum logic {ANALOG = 1'b0, MOUSE = 1'b1} src_e;

  // Saturate a signed value to the range of a w-bit two's-complement number.
  function automatic int sat_w(input int value, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (value > hi) ? hi : ((value < lo) ? lo : value);
  endfunction

  function automatic int clamp_step(input int value, input int max_step);
    return (value > max_step) ? max_step : ((value < -max_step) ? -max_step : value);
  endfunction

endpackage

// File: rtl/mouse_paddle_emu_axis.sv
// One paddle axis: delta shaping (stage 1), saturating accumulate (stage 2)
// and spring-return decay.
module paddle_axis_acc
  import mouse_paddle_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_STEP = 10
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                i_load,
  input  logic                i_sign,
  input  logic [7:0]          i_mag,
  input  logic [1:0]          i_sens,
  input  logic                i_inv,
  input  logic                i_s1_vld,
  input  logic                i_clear,
  input  logic                i_decay,
  output logic signed [W-1:0] o_acc
);

  logic signed [8:0] w_d;
  logic signed [8:0] w_sh;
  int                w_cl;
  int                w_step;
  int                w_sum;
  logic signed [W:0] r_step;
  logic signed [W-1:0] r_acc;

  assign w_d    = {i_sign, i_mag};
  assign w_sh   = w_d >>> i_sens;
  assign w_cl   = clamp_step(int'(w_sh), MAX_STEP);
  assign w_step = i_inv ? -w_cl : w_cl;
  assign w_sum  = sat_w(int'(r_acc) + int'(r_step), W);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_step <= '0;
    end else if (i_load) begin
      r_step <= (W+1)'(w_step);
    end
  end

  // An accumulate on the decay cycle wins; that decay step is simply lost.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_s1_vld) begin
      r_acc <= W'(w_sum);
    end else if (i_decay && (r_acc != '0)) begin
      r_acc <= r_acc[W-1] ? r_acc + W'(1) : r_acc - W'(1);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mouse_paddle_emu.sv
// Mouse-to-paddle emulator top: strobe detect, source arbitration against the
// analog stick, spring-return prescaler and registered paddle outputs.
module mouse_paddle_emu
  import mouse_paddle_pkg::*;
#(
  parameter int W            = 8,
  parameter int MAX_STEP     = 10,
  parameter int DECAY_PERIOD = 65536
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [24:0]         ps2_mouse,
  input  logic [15:0]         joya,
  input  logic [1:0]          sens,
  input  logic [1:0]          inv,
  input  logic                center_en,
  output logic signed [W-1:0] ax,
  output logic signed [W-1:0] ay,
  output logic [2:0]          btn,
  output logic                src_mouse,
  output logic                upd
);

  localparam int PW = $clog2(DECAY_PERIOD);

  src_e            r_state;
  src_e            w_state_nxt;
  logic            r_armed;
  logic            r_old_stb;
  logic [PW-1:0]   r_pre;
  logic [2:0]      r_vld_pipe;
  logic [2:0]      r_btn1;
  logic            w_joy_nz;
  logic            w_accept;
  logic            w_wrap;
  logic            w_decay;
  logic [1:0]      w_sign;
  logic [1:0][7:0] w_mag;
  logic [1:0][W-1:0] w_acc;
  logic [1:0][W-1:0] w_joy;
  logic            w_unused;

  assign w_unused = ^{ps2_mouse[7:6], ps2_mouse[3]};
  assign w_joy_nz = (joya != 16'h0000);
  // The stick always wins, so a packet arriving with it is dropped here.
  assign w_accept = r_armed && (ps2_mouse[24] != r_old_stb) && !w_joy_nz;
  assign w_wrap   = (r_pre == PW'(DECAY_PERIOD - 1));
  assign w_decay  = w_wrap && center_en && (r_state == MOUSE);

  assign w_sign = {ps2_mouse[5], ps2_mouse[4]};
  assign w_mag  = {ps2_mouse[23:16], ps2_mouse[15:8]};
  assign w_joy  = {W'(int'($signed(joya[15:8]))), W'(int'($signed(joya[7:0])))};

  for (genvar g = 0; g < 2; g++) begin : g_axis
    paddle_axis_acc #(.W(W), .MAX_STEP(MAX_STEP)) u_axis (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .i_load   (w_accept),
      .i_sign   (w_sign[g]),
      .i_mag    (w_mag[g]),
      .i_sens   (sens),
      .i_inv    (inv[g]),
      .i_s1_vld (r_vld_pipe[0]),
      .i_clear  (w_joy_nz),
      .i_decay  (w_decay),
      .o_acc    (w_acc[g])
    );
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= ANALOG;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_joy_nz)      w_state_nxt = ANALOG;
    else if (w_accept) w_state_nxt = MOUSE;
  end

  // Armed on the first clock so a strobe level held across reset is not a packet.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_armed   <= 1'b0;
      r_old_stb <= 1'b0;
      r_pre     <= '0;
    end else begin
      r_armed   <= 1'b1;
      r_old_stb <= ps2_mouse[24];
      r_pre     <= w_wrap ? '0 : r_pre + PW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_btn1     <= '0;
      btn        <= '0;
    end else if (w_joy_nz) begin
      r_vld_pipe <= '0;
      btn        <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], w_accept};
      if (w_accept)      r_btn1 <= ps2_mouse[2:0];
      if (r_vld_pipe[0]) btn    <= r_btn1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ax <= '0;
      ay <= '0;
    end else if ((r_state == MOUSE) && !w_joy_nz) begin
      ax <= w_acc[0];
      ay <= w_acc[1];
    end else begin
      ax <= w_joy[0];
      ay <= w_joy[1];
    end
  end

  assign src_mouse = (r_state == MOUSE);
  assign upd       = r_vld_pipe[2];

endmodule
